// File: rtl/bank_biu_linefill_rd.sv
// Linefill read unit: queues line requests, issues one 2-beat AXI read per line,
// and assembles the two 128-bit beats into a 256-bit line for the issue unit.
module bank_biu_linefill_rd #(
  parameter int ADDR_WIDTH = 32,
  parameter int REQ_DEPTH  = 4,
  parameter int OST_MAX    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  htu_biu_req_valid_i,
  output logic                  htu_biu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] htu_biu_req_addr_i,
  input  logic [2:0]            htu_biu_req_set_i,
  input  logic [2:0]            htu_biu_req_way_i,
  output logic                  axi_arvalid_o,
  input  logic                  axi_arready_i,
  output logic [ADDR_WIDTH-1:0] axi_araddr_o,
  output logic [5:0]            axi_arid_o,
  output logic [7:0]            axi_arlen_o,
  output logic [2:0]            axi_arsize_o,
  output logic [1:0]            axi_arburst_o,
  input  logic                  axi_rvalid_i,
  output logic                  axi_rready_o,
  input  logic [127:0]          axi_rdata_i,
  input  logic [5:0]            axi_rid_i,
  input  logic                  axi_rlast_i,
  input  logic [1:0]            axi_rresp_i,
  output logic                  biu_isu_rvalid_o,
  input  logic                  biu_isu_rready_i,
  output logic [255:0]          biu_isu_rdata_o,
  output logic [5:0]            biu_isu_rid_o,
  output logic                  biu_err_o
);

  localparam int         PW        = $clog2(REQ_DEPTH);
  localparam logic [6:0] OST_MAX_C = 7'(OST_MAX);
  localparam logic [1:0] R_BEAT0   = 2'd0;
  localparam logic [1:0] R_BEAT1   = 2'd1;
  localparam logic [1:0] R_OUT     = 2'd2;

  logic [ADDR_WIDTH-1:0] addr_mem_q [REQ_DEPTH];
  logic [5:0]            id_mem_q   [REQ_DEPTH];
  logic [PW:0]           wr_ptr_q, wr_ptr_d;
  logic [PW:0]           rd_ptr_q, rd_ptr_d;
  logic                  fifo_empty, fifo_full, push, pop;
  logic [6:0]            ost_cnt_q, ost_cnt_d;
  logic                  ar_hs, r_hs, isu_hs;
  logic [1:0]            state_q, state_d;
  logic [127:0]          lo_q, lo_d, hi_q, hi_d;
  logic [5:0]            id_q, id_d;
  logic                  err_q, err_d;
  logic                  rready_q, rvalid_q;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push       = htu_biu_req_valid_i && !fifo_full;
  assign pop        = ar_hs;
  assign wr_ptr_d   = push ? (wr_ptr_q + {{PW{1'b0}}, 1'b1}) : wr_ptr_q;
  assign rd_ptr_d   = pop  ? (rd_ptr_q + {{PW{1'b0}}, 1'b1}) : rd_ptr_q;

  assign htu_biu_req_ready_o = !fifo_full;
  assign axi_arvalid_o = !fifo_empty && (ost_cnt_q < OST_MAX_C);
  assign axi_araddr_o  = {addr_mem_q[rd_ptr_q[PW-1:0]][ADDR_WIDTH-1:5], 5'b0_0000};
  assign axi_arid_o    = id_mem_q[rd_ptr_q[PW-1:0]];
  assign axi_arlen_o   = 8'd1;
  assign axi_arsize_o  = 3'd4;
  assign axi_arburst_o = 2'b01;

  assign ar_hs  = axi_arvalid_o && axi_arready_i;
  assign r_hs   = axi_rvalid_i && rready_q;
  assign isu_hs = rvalid_q && biu_isu_rready_i;

  assign axi_rready_o     = rready_q;
  assign biu_isu_rvalid_o = rvalid_q;
  assign biu_isu_rdata_o  = {hi_q, lo_q};
  assign biu_isu_rid_o    = id_q;
  assign biu_err_o        = err_q;

  // Request storage needs no reset: entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem_q[wr_ptr_q[PW-1:0]] <= htu_biu_req_addr_i;
      id_mem_q[wr_ptr_q[PW-1:0]]   <= {htu_biu_req_set_i, htu_biu_req_way_i};
    end
  end

  always_comb begin
    ost_cnt_d = ost_cnt_q;
    case ({ar_hs, isu_hs})
      2'b10:   ost_cnt_d = ost_cnt_q + 7'd1;
      2'b01:   ost_cnt_d = ost_cnt_q - 7'd1;
      default: ost_cnt_d = ost_cnt_q;
    endcase
  end

  // Beat assembly; the line is still delivered after a protocol error.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    id_d    = id_q;
    err_d   = err_q;
    case (state_q)
      R_BEAT0: begin
        if (r_hs) begin
          lo_d = axi_rdata_i;
          id_d = axi_rid_i;
          if (axi_rlast_i) begin
            err_d = 1'b1;
          end else begin
            state_d = R_BEAT1;
          end
        end else begin
          state_d = R_BEAT0;
        end
      end
      R_BEAT1: begin
        if (r_hs) begin
          hi_d    = axi_rdata_i;
          state_d = R_OUT;
          if (!axi_rlast_i || (axi_rid_i != id_q)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          state_d = R_BEAT1;
        end
      end
      R_OUT: begin
        if (biu_isu_rready_i) begin
          state_d = R_BEAT0;
        end else begin
          state_d = R_OUT;
        end
      end
      default: state_d = R_BEAT0;
    endcase
    if (r_hs && (axi_rresp_i != 2'b00)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ost_cnt_q <= 7'd0;
      state_q   <= R_BEAT0;
      lo_q      <= 128'd0;
      hi_q      <= 128'd0;
      id_q      <= 6'd0;
      err_q     <= 1'b0;
      rready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ost_cnt_q <= ost_cnt_d;
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      id_q      <= id_d;
      err_q     <= err_d;
      rready_q  <= (state_d != R_OUT);
      rvalid_q  <= (state_d == R_OUT);
    end
  end

endmodule

// File: tb/tb_bank_biu_linefill_rd.sv
// Directed bench for bank_biu_linefill_rd; a second instance with OST_MAX=2
// shares the inputs and is checked only in the outstanding-cap step.
module tb_bank_biu_linefill_rd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic [2:0]   req_set, req_way;
  logic         arready;
  logic         rvalid;
  logic [127:0] rdata;
  logic [5:0]   rid;
  logic         rlast;
  logic [1:0]   rresp;
  logic         isu_rready;

  logic         req_ready, arvalid, rready, isu_rvalid, err;
  logic [31:0]  araddr;
  logic [5:0]   arid, isu_rid;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [255:0] isu_rdata;

  logic         d2_req_ready, d2_arvalid, d2_rready, d2_isu_rvalid, d2_err;
  logic [31:0]  d2_araddr;
  logic [5:0]   d2_arid, d2_isu_rid;
  logic [7:0]   d2_arlen;
  logic [2:0]   d2_arsize;
  logic [1:0]   d2_arburst;
  logic [255:0] d2_isu_rdata;

  int checks = 0;
  int errors = 0;

  bank_biu_linefill_rd dut (
    .clk_i(clk), .rst_i(rst),
    .htu_biu_req_valid_i(req_valid), .htu_biu_req_ready_o(req_ready),
    .htu_biu_req_addr_i(req_addr), .htu_biu_req_set_i(req_set), .htu_biu_req_way_i(req_way),
    .axi_arvalid_o(arvalid), .axi_arready_i(arready), .axi_araddr_o(araddr),
    .axi_arid_o(arid), .axi_arlen_o(arlen), .axi_arsize_o(arsize), .axi_arburst_o(arburst),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready), .axi_rdata_i(rdata), .axi_rid_i(rid),
    .axi_rlast_i(rlast), .axi_rresp_i(rresp),
    .biu_isu_rvalid_o(isu_rvalid), .biu_isu_rready_i(isu_rready),
    .biu_isu_rdata_o(isu_rdata), .biu_isu_rid_o(isu_rid), .biu_err_o(err)
  );

  bank_biu_linefill_rd #(.ADDR_WIDTH(32), .REQ_DEPTH(4), .OST_MAX(2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .htu_biu_req_valid_i(req_valid), .htu_biu_req_ready_o(d2_req_ready),
    .htu_biu_req_addr_i(req_addr), .htu_biu_req_set_i(req_set), .htu_biu_req_way_i(req_way),
    .axi_arvalid_o(d2_arvalid), .axi_arready_i(arready), .axi_araddr_o(d2_araddr),
    .axi_arid_o(d2_arid), .axi_arlen_o(d2_arlen), .axi_arsize_o(d2_arsize), .axi_arburst_o(d2_arburst),
    .axi_rvalid_i(rvalid), .axi_rready_o(d2_rready), .axi_rdata_i(rdata), .axi_rid_i(rid),
    .axi_rlast_i(rlast), .axi_rresp_i(rresp),
    .biu_isu_rvalid_o(d2_isu_rvalid), .biu_isu_rready_i(isu_rready),
    .biu_isu_rdata_o(d2_isu_rdata), .biu_isu_rid_o(d2_isu_rid), .biu_err_o(d2_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic [2:0] s, input logic [2:0] w);
    req_valid = 1'b1;
    req_addr  = a;
    req_set   = s;
    req_way   = w;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic beat(input logic [127:0] d, input logic [5:0] i, input logic l, input logic [1:0] r);
    rvalid = 1'b1;
    rdata  = d;
    rid    = i;
    rlast  = l;
    rresp  = r;
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // A line delivered while nothing is outstanding would underflow the counter.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(dut.ost_cnt_q == 7'd0 && isu_rvalid && isu_rready && !(arvalid && arready))) else begin
        errors++;
        $error("FAIL ost_underflow: observed decrement at count 0 expected none");
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  logic [31:0]  f_addr [4];
  logic [31:0]  f_exp  [4];
  logic [5:0]   f_id   [4];
  logic [127:0] da, db, dc, dd;
  int           hs_cnt;

  initial begin
    f_addr = '{32'h1000_001F, 32'h2000_0027, 32'h3000_0040, 32'h4000_007C};
    f_exp  = '{32'h1000_0000, 32'h2000_0020, 32'h3000_0040, 32'h4000_0060};
    f_id   = '{6'o07, 6'o16, 6'o25, 6'o34};
    da = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    db = 128'hBBBB_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
    dc = 128'hCCCC_0123_4567_89AB_CDEF_0123_4567_89AB;
    dd = 128'hDDDD_FEDC_BA98_7654_3210_FEDC_BA98_7654;

    rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_set = 3'd0; req_way = 3'd0;
    arready = 1'b0; rvalid = 1'b0; rdata = 128'd0; rid = 6'd0; rlast = 1'b0;
    rresp = 2'b00; isu_rready = 1'b1;
    tick();
    tick();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_isu_rvalid", isu_rvalid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    rst = 1'b0;
    tick();
    chk("beat0_rready", rready, 1'b1);

    // Single fill
    push_req(32'h1234_5678, 3'd3, 3'd5);
    chk("ar_valid", arvalid, 1'b1);
    chk("ar_addr", araddr, 32'h1234_5660);
    chk("ar_id", arid, 6'o35);
    chk("ar_len", arlen, 8'd1);
    chk("ar_size", arsize, 3'd4);
    chk("ar_burst", arburst, 2'b01);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("ar_done", arvalid, 1'b0);
    chk("ost_one", dut.ost_cnt_q, 7'd1);
    beat(da, 6'o35, 1'b0, 2'b00);
    chk("no_line_yet", isu_rvalid, 1'b0);
    beat(db, 6'o35, 1'b1, 2'b00);
    chk("line_valid", isu_rvalid, 1'b1);
    chk("line_data", isu_rdata, {db, da});
    chk("line_id", isu_rid, 6'o35);
    chk("line_rready_low", rready, 1'b0);
    tick();
    chk("line_gone", isu_rvalid, 1'b0);
    chk("ost_zero", dut.ost_cnt_q, 7'd0);
    chk("fill_err", err, 1'b0);

    // FIFO full with AR back-pressure
    for (int i = 0; i < 4; i++) begin
      push_req(f_addr[i], 3'(i), 3'(7 - i));
      if (i == 2) chk("fifo_3_ready", req_ready, 1'b1);
    end
    chk("fifo_full_ready", req_ready, 1'b0);
    arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fifo_ar_valid", arvalid, 1'b1);
      chk("fifo_ar_addr", araddr, f_exp[i]);
      chk("fifo_ar_id", arid, f_id[i]);
      tick();
      if (i == 0) chk("fifo_ready_back", req_ready, 1'b1);
    end
    chk("fifo_drained", arvalid, 1'b0);
    chk("fifo_ost", dut.ost_cnt_q, 7'd4);
    arready = 1'b0;
    do_reset();
    chk("rst2_ost", dut.ost_cnt_q, 7'd0);

    // Consumer stall
    arready = 1'b1;
    push_req(32'h0000_0100, 3'd1, 3'd1);
    push_req(32'h0000_0200, 3'd2, 3'd2);
    tick();
    arready = 1'b0;
    chk("stall_ost", dut.ost_cnt_q, 7'd2);
    isu_rready = 1'b0;
    beat(da, 6'o11, 1'b0, 2'b00);
    beat(db, 6'o11, 1'b1, 2'b00);
    rvalid = 1'b1; rdata = dc; rid = 6'o22; rlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", isu_rvalid, 1'b1);
      chk("stall_data", isu_rdata, {db, da});
      chk("stall_id", isu_rid, 6'o11);
      chk("stall_rready", rready, 1'b0);
      tick();
    end
    isu_rready = 1'b1;
    tick();
    chk("release_valid", isu_rvalid, 1'b0);
    chk("release_rready", rready, 1'b1);
    tick();
    rdata = dd; rlast = 1'b1;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    chk("next_valid", isu_rvalid, 1'b1);
    chk("next_data", isu_rdata, {dd, dc});
    chk("next_id", isu_rid, 6'o22);
    tick();
    chk("stall_ost_zero", dut.ost_cnt_q, 7'd0);

    // Errors: early last on beat0, then bad response on beat1
    arready = 1'b1;
    push_req(32'h0000_0300, 3'd4, 3'd2);
    tick();
    arready = 1'b0;
    beat(da, 6'o42, 1'b1, 2'b00);
    chk("early_last_err", err, 1'b1);
    chk("early_last_noline", isu_rvalid, 1'b0);
    chk("early_last_rready", rready, 1'b1);
    beat(dc, 6'o42, 1'b0, 2'b00);
    beat(dd, 6'o42, 1'b1, 2'b10);
    chk("resp_line_valid", isu_rvalid, 1'b1);
    chk("resp_line_data", isu_rdata, {dd, dc});
    chk("resp_line_id", isu_rid, 6'o42);
    tick();
    chk("err_sticky", err, 1'b1);

    // Reset between beat0 and beat1
    arready = 1'b1;
    push_req(32'h0000_0400, 3'd5, 3'd6);
    tick();
    arready = 1'b0;
    beat(da, 6'o56, 1'b0, 2'b00);
    rst = 1'b1;
    tick();
    chk("mid_rst_arvalid", arvalid, 1'b0);
    chk("mid_rst_rready", rready, 1'b0);
    chk("mid_rst_isu_rvalid", isu_rvalid, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_ost", dut.ost_cnt_q, 7'd0);
    rst = 1'b0;
    tick();
    arready = 1'b1;
    push_req(32'h0000_0500, 3'd6, 3'd7);
    chk("fresh_ar_id", arid, 6'o67);
    tick();
    arready = 1'b0;
    beat(db, 6'o67, 1'b0, 2'b00);
    beat(dc, 6'o67, 1'b1, 2'b00);
    chk("fresh_valid", isu_rvalid, 1'b1);
    chk("fresh_data", isu_rdata, {dc, db});
    chk("fresh_err", err, 1'b0);
    tick();
    chk("fresh_ost", dut.ost_cnt_q, 7'd0);

    // Outstanding cap on the OST_MAX=2 instance
    do_reset();
    arready = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = (i < 3);
      req_addr  = f_addr[i % 4];
      req_set   = 3'(i);
      req_way   = 3'(7 - i);
      if (d2_arvalid && arready) hs_cnt++;
      tick();
    end
    req_valid = 1'b0;
    chk("cap_hs_count", 32'(hs_cnt), 32'd2);
    chk("cap_arvalid_low", d2_arvalid, 1'b0);
    chk("cap_ost", dut2.ost_cnt_q, 7'd2);
    beat(da, f_id[0], 1'b0, 2'b00);
    beat(db, f_id[0], 1'b1, 2'b00);
    chk("cap_line_valid", d2_isu_rvalid, 1'b1);
    tick();
    chk("cap_third_arvalid", d2_arvalid, 1'b1);
    chk("cap_third_addr", d2_araddr, f_exp[2]);
    chk("cap_third_id", d2_arid, f_id[2]);
    tick();
    chk("cap_third_taken", d2_arvalid, 1'b0);
    arready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_biu_linefill_rd.md
Name: bank_biu_linefill_rd

Overview:
- Bank-side bus read unit for cache linefills.
- Accepts linefill requests (set, way, line address) from the hit-test stage and issues one AXI read burst per line, with ID = {set, way}.
- Assembles the two 128-bit R beats into one 256-bit line and delivers it to the issue unit on the biu_isu_* return channel.
- The issue unit also uses this channel to clear its in-flight array and to fill its linefill buffer.

Parameters:
- ADDR_WIDTH, 32, byte address width of the line request and of ARADDR.
- REQ_DEPTH, 4, request FIFO entries; power of two, at least 2.
- OST_MAX, 8, maximum AR bursts issued but not yet delivered to the issue unit; range 1..64.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- htu_biu_req_valid_i  in  1  linefill request valid
- htu_biu_req_ready_o  out  1  request accepted when valid & ready
- htu_biu_req_addr_i  in  ADDR_WIDTH  line byte address
- htu_biu_req_set_i  in  3  target set
- htu_biu_req_way_i  in  3  target way
- axi_arvalid_o  out  1  AR valid
- axi_arready_i  in  1  AR ready
- axi_araddr_o  out  ADDR_WIDTH  32-byte-aligned address
- axi_arid_o  out  6  {set, way}
- axi_arlen_o  out  8  constant 8'd1 (2 beats)
- axi_arsize_o  out  3  constant 3'd4 (16 bytes per beat)
- axi_arburst_o  out  2  constant 2'b01 (INCR)
- axi_rvalid_i  in  1  R valid
- axi_rready_o  out  1  R ready
- axi_rdata_i  in  128  R data
- axi_rid_i  in  6  R id
- axi_rlast_i  in  1  R last
- axi_rresp_i  in  2  R response
- biu_isu_rvalid_o  out  1  assembled line valid
- biu_isu_rready_i  in  1  issue unit ready (currently tied 1 by the consumer)
- biu_isu_rdata_o  out  256  line; [127:0] = offset0 (beat0), [255:128] = offset1 (beat1)
- biu_isu_rid_o  out  6  {set, way} of the line
- biu_err_o  out  1  sticky protocol/response error

Behaviour:
- Clocking and reset: single clock, synchronous active-high reset on rst_i.
- Reset values: axi_arvalid_o=0, axi_rready_o=0, biu_isu_rvalid_o=0, biu_err_o=0, FIFO empty, outstanding count 0, R FSM in R_BEAT0. Data and ID outputs are don't-care while their valid is low.
- Reset asserted mid-operation: the FIFO, outstanding count, partial line and FSM are all cleared. The memory side is reset in the same domain; no drain occurs.

Request FIFO:
- htu_biu_req_ready_o = !full; this does not depend on valid.
- Push on valid & ready. Pointers wrap modulo REQ_DEPTH, with one extra bit for full/empty.
- Push and pop in the same cycle when full: push is blocked, because ready is low.
- Push and pop in the same cycle when not full: both happen and occupancy is unchanged.

AR issue:
- axi_arvalid_o = FIFO not empty & (ost_cnt < OST_MAX), driven from the FIFO head.
- axi_araddr_o = head address with bits [4:0] forced to 0.
- axi_arid_o = {head set, head way}.
- Once arvalid is high, it and all AR fields stay stable until arready.
- Pop the FIFO on the AR handshake.
- Latency: a request pushed into an empty FIFO at cycle N drives arvalid at cycle N+1.

Outstanding counter (ost_cnt, 7 bits):
- +1 on AR handshake; -1 on the biu_isu handshake; both in the same cycle leaves it unchanged.
- Never exceeds OST_MAX.
- A decrement at 0 is impossible by construction; the bench asserts on it.

R assembly FSM (states R_BEAT0, R_BEAT1, R_OUT):
- Bursts are never interleaved on R; the interconnect guarantees this.
- R_BEAT0: rready=1. On rvalid, capture rdata into lo_q and rid into id_q.
  - rlast=1 (early last): set biu_err_o, discard the beat, stay in R_BEAT0.
  - Otherwise go to R_BEAT1.
- R_BEAT1: rready=1. On rvalid, capture rdata into hi_q and go to R_OUT.
  - rlast=0 or rid != id_q: set biu_err_o; the line is still delivered with id_q.
- Any beat with rresp != 2'b00 sets biu_err_o; the data is delivered unchanged.
- R_OUT: rready=0, biu_isu_rvalid_o=1, rdata={hi_q, lo_q}, rid=id_q.
  - On biu_isu_rready_i go to R_BEAT0.
  - Outputs stay stable while the consumer stalls.
- Latency: the last beat accepted at cycle N gives biu_isu_rvalid_o at N+1. The next beat0 can be accepted at N+2 at the earliest when the consumer is always ready, i.e. 3 cycles per line.
- biu_err_o clears only on reset.

Test Plan:
- Single fill: request addr 0x1234_5678, set 3, way 5 -> AR with addr 0x1234_5660, id 6'o35, len 1, size 4, burst 1; beats A then B -> rvalid one cycle after B with rdata={B,A}, rid 6'o35; ost_cnt returns to 0.
- FIFO full: hold arready=0 and push 4 requests -> req_ready=0 after the 4th push; then arready=1 -> 4 AR in order; ready rises the cycle after the first pop.
- Outstanding cap, OST_MAX=2: push 3 requests, never return R -> exactly 2 AR handshakes, arvalid low; deliver one line -> third AR issued the next cycle.
- Consumer stall: biu_isu_rready_i=0 for 5 cycles with a line pending -> rvalid, rdata and rid stable, rready=0, next burst beats not accepted; release -> next burst proceeds.
- Errors: beat0 with rlast=1 -> biu_err_o=1, no line delivered; rresp=2'b10 on beat1 -> line delivered, err stays 1 until rst_i.
- Reset between beat0 and beat1 -> all outputs at reset values next cycle; a fresh request completes normally afterwards.
